// File: rtl/sprite_overlay_ctrl.sv
// Keyed-sprite overlay stage: addresses an external sprite ROM and composites its pixel over the background.
// Optional frame-counted blinking is compiled in with `define SPRITE_BLINK_EN.
module sprite_overlay_ctrl #(
    parameter int          W          = 24,
    parameter int          H          = 11,
    parameter int          ROW_W      = 4,
    parameter int          COL_W      = 5,
    parameter int          ROM_LAT    = 1,
    parameter int          SCALE_LOG2 = 0,
    parameter logic [11:0] KEY        = 12'hFFF,
    parameter logic [9:0]  X_RST      = 10'd265,
    parameter logic [9:0]  Y_RST      = 10'd277,
    parameter int          BLINK_FR   = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bright,
    input  logic [9:0]       hCount,
    input  logic [9:0]       vCount,
    input  logic [9:0]       x_pos,
    input  logic [9:0]       y_pos,
    input  logic [11:0]      background,
    output logic [ROW_W-1:0] rom_row,
    output logic [COL_W-1:0] rom_col,
    input  logic [11:0]      rom_color,
    output logic [11:0]      rgb,
    output logic             sprite_hit
);

    localparam logic [10:0] WIN_W = 11'(W << SCALE_LOG2);
    localparam logic [10:0] WIN_H = 11'(H << SCALE_LOG2);

    typedef enum logic {
        S_OFF = 1'b0,
        S_ON  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic        frame_start;
    logic [9:0]  x_q, y_q, x_eff, y_eff;
    logic [10:0] dx, dy;
    logic        visible;
    logic        win;

    logic [ROM_LAT-1:0] win_sr;
    logic [ROM_LAT-1:0] bright_sr;
    logic [11:0]        bg_sr [ROM_LAT];

    // The frame_start pixel already uses the new state and position, so a
    // frame switches cleanly at (0,0) with no one-pixel lag.
    always_comb begin
        frame_start = (hCount == 10'd0) && (vCount == 10'd0);
        state_nxt   = state;
        if (frame_start) begin
            state_nxt = en ? S_ON : S_OFF;
        end
        x_eff = frame_start ? x_pos : x_q;
        y_eff = frame_start ? y_pos : y_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_OFF;
            x_q   <= X_RST;
            y_q   <= Y_RST;
        end else begin
            state <= state_nxt;
            if (frame_start) begin
                x_q <= x_pos;
                y_q <= y_pos;
            end
        end
    end

`ifdef SPRITE_BLINK_EN
    logic [7:0] blink_cnt, blink_cnt_nxt;

    always_comb begin
        blink_cnt_nxt = blink_cnt;
        if (frame_start) begin
            blink_cnt_nxt = (state == S_ON && state_nxt == S_ON) ? blink_cnt + 8'd1 : 8'd0;
        end
        visible = (((32'(blink_cnt_nxt) / BLINK_FR) % 2) == 0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_cnt <= 8'd0;
        end else begin
            blink_cnt <= blink_cnt_nxt;
        end
    end
`else
    always_comb begin
        visible = 1'b1;
    end
`endif

    // 11-bit differences: a pixel left of/above the sprite wraps to a huge value,
    // so one unsigned compare covers both bounds and right-edge clipping.
    always_comb begin
        dx      = {1'b0, hCount} - {1'b0, x_eff};
        dy      = {1'b0, vCount} - {1'b0, y_eff};
        win     = (state_nxt == S_ON) && visible && (dx < WIN_W) && (dy < WIN_H);
        rom_col = COL_W'(dx >> SCALE_LOG2);
        rom_row = ROW_W'(dy >> SCALE_LOG2);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            win_sr    <= '0;
            bright_sr <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                bg_sr[i] <= 12'd0;
            end
        end else begin
            win_sr[0]    <= win;
            bright_sr[0] <= bright;
            bg_sr[0]     <= background;
            for (int i = 1; i < ROM_LAT; i++) begin
                win_sr[i]    <= win_sr[i-1];
                bright_sr[i] <= bright_sr[i-1];
                bg_sr[i]     <= bg_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb        <= 12'd0;
            sprite_hit <= 1'b0;
        end else if (!bright_sr[ROM_LAT-1]) begin
            rgb        <= 12'd0;
            sprite_hit <= 1'b0;
        end else if (win_sr[ROM_LAT-1] && rom_color != KEY) begin
            rgb        <= rom_color;
            sprite_hit <= 1'b1;
        end else begin
            rgb        <= bg_sr[ROM_LAT-1];
            sprite_hit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_overlay_ctrl.sv
// Directed bench for sprite_overlay_ctrl: two instances (1x and 2x scale) share inputs,
// each fed by its own 1-cycle ROM model; expectations are hand-computed per pixel.
module tb_sprite_overlay_ctrl;

    // clock / reset / inputs
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        bright;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic [11:0] background;

    logic [3:0]  rom_row_a, rom_row_b;
    logic [4:0]  rom_col_a, rom_col_b;
    logic [11:0] rom_color_a, rom_color_b;
    logic [11:0] rgb_a, rgb_b;
    logic        hit_a, hit_b;

    always #5 clk = ~clk;

    sprite_overlay_ctrl #(.SCALE_LOG2(0), .BLINK_FR(2)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .bright(bright), .hCount(h_count), .vCount(v_count),
        .x_pos(x_pos), .y_pos(y_pos), .background(background), .rom_row(rom_row_a),
        .rom_col(rom_col_a), .rom_color(rom_color_a), .rgb(rgb_a), .sprite_hit(hit_a)
    );

    sprite_overlay_ctrl #(.SCALE_LOG2(1), .BLINK_FR(2)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .bright(bright), .hCount(h_count), .vCount(v_count),
        .x_pos(x_pos), .y_pos(y_pos), .background(background), .rom_row(rom_row_b),
        .rom_col(rom_col_b), .rom_color(rom_color_b), .rgb(rgb_b), .sprite_hit(hit_b)
    );

    // Sprite image: (0,0) red, every column with col%4==3 transparent, else {A,row,col[3:0]}.
    function automatic logic [11:0] rom_pix(input logic [3:0] r, input logic [4:0] c);
        if (r == 4'd0 && c == 5'd0) return 12'hF00;
        if (c[1:0] == 2'b11)        return 12'hFFF;
        return {4'hA, r, c[3:0]};
    endfunction

    always @(posedge clk) begin
        rom_color_a <= rom_pix(rom_row_a, rom_col_a);
        rom_color_b <= rom_pix(rom_row_b, rom_col_b);
    end

    // expected entry: {care, hit, rgb}
    function automatic logic [13:0] sp(input logic [11:0] c);
        return {1'b1, 1'b1, c};
    endfunction
    function automatic logic [13:0] bg(input logic [11:0] c);
        return {1'b1, 1'b0, c};
    endfunction
    localparam logic [13:0] BLANK = {1'b1, 1'b0, 12'h000};
    localparam logic [13:0] DC    = 14'h0000;

    // scoreboard
    logic [27:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got hit=%0b rgb=%03h, expected hit=%0b rgb=%03h",
                     tag, got[12], got[11:0], exp[12], exp[11:0]);
        end
    endtask

    // Output after edge k reflects inputs sampled at edge k-1, so the oldest of three entries is due.
    always @(negedge clk) begin
        logic [27:0] e;
        string       t;
        if (exp_q.size() > 2) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e[27]) check({t, "_a"}, {hit_a, rgb_a}, e[26:14]);
            if (e[13]) check({t, "_b"}, {hit_b, rgb_b}, e[12:0]);
        end
    end

    // driver: one pixel per clock, inputs change 1 time unit after the edge
    task automatic cyc(input logic [9:0] h, input logic [9:0] v,
                       input logic [13:0] ea, input logic [13:0] eb, input string tag);
        h_count = h;
        v_count = v;
        exp_q.push_back({ea, eb});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] vis;
        rst = 1'b0; en = 1'b1; bright = 1'b1; background = 12'h00F;
        x_pos = 10'd265; y_pos = 10'd277; h_count = 10'd5; v_count = 10'd5;
        @(posedge clk);
        #1;

        // reset, then background while OFF (en ignored until frame start)
        cyc(5, 5, BLANK, BLANK, "rst0");
        cyc(5, 5, BLANK, BLANK, "rst1");
        rst = 1'b1;
        cyc(5, 5, bg(12'h00F), bg(12'h00F), "off_bg");
        cyc(270, 280, bg(12'h00F), bg(12'h00F), "off_in_win");

        // frame start turns sprite on; 1x and 2x windows
        cyc(0, 0, bg(12'h00F), bg(12'h00F), "fs_on");
        cyc(265, 277, sp(12'hF00), sp(12'hF00), "origin");
        cyc(266, 277, sp(12'hA01), sp(12'hF00), "col1");
        cyc(268, 277, bg(12'h00F), sp(12'hA01), "key_col3");
        cyc(270, 279, sp(12'hA25), sp(12'hA12), "mid");
        cyc(287, 287, sp(12'hAA6), bg(12'h00F), "corner");
        cyc(289, 280, bg(12'h00F), sp(12'hA1C), "past_w");
        cyc(310, 280, bg(12'h00F), sp(12'hA16), "scaled_edge");
        cyc(313, 280, bg(12'h00F), bg(12'h00F), "scaled_out");
        cyc(265, 288, bg(12'h00F), sp(12'hA50), "past_h");
        cyc(265, 299, bg(12'h00F), bg(12'h00F), "scaled_below");
        cyc(264, 277, bg(12'h00F), bg(12'h00F), "left_of");
        bright = 1'b0;
        cyc(266, 277, BLANK, BLANK, "dark_in_win");
        bright = 1'b1;

        // en drop and x_pos change mid-frame take effect only at next frame start
        en = 1'b0; x_pos = 10'd300;
        cyc(5, 100, bg(12'h00F), bg(12'h00F), "en_drop");
        cyc(265, 277, sp(12'hF00), sp(12'hF00), "still_on");
        x_pos = 10'd265;
        cyc(0, 0, bg(12'h00F), bg(12'h00F), "fs_off");
        cyc(265, 277, bg(12'h00F), bg(12'h00F), "gone");
        en = 1'b1;
        cyc(0, 0, bg(12'h00F), bg(12'h00F), "fs_on2");
        x_pos = 10'd300;
        cyc(265, 277, sp(12'hF00), sp(12'hF00), "old_pos");
        cyc(300, 277, bg(12'h00F), sp(12'hA01), "old_pos_b");
        cyc(0, 0, bg(12'h00F), bg(12'h00F), "fs_move");
        cyc(265, 277, bg(12'h00F), bg(12'h00F), "old_spot");
        cyc(300, 277, sp(12'hF00), sp(12'hF00), "new_pos");

        // reset in the middle of the sprite blanks the next output
        cyc(301, 277, BLANK, BLANK, "rst_mid");
        rst = 1'b0;
        cyc(302, 277, BLANK, BLANK, "rst_mid2");
        rst = 1'b1; x_pos = 10'd1010; y_pos = 10'd277;
        cyc(1012, 278, bg(12'h00F), bg(12'h00F), "off_after_rst");

        // right-edge clipping, no wrap to column 0
        cyc(0, 0, bg(12'h00F), bg(12'h00F), "fs_clip");
        cyc(1010, 277, sp(12'hF00), sp(12'hF00), "clip_origin");
        cyc(1023, 278, sp(12'hA1D), sp(12'hA06), "clip_last");
        cyc(0, 278, bg(12'h00F), bg(12'h00F), "no_wrap0");
        cyc(9, 278, bg(12'h00F), bg(12'h00F), "no_wrap9");

`ifdef SPRITE_BLINK_EN
        // blink with 2-frame half period: visible, visible, hidden, hidden, ...
        en = 1'b0;
        cyc(5, 5, BLANK, BLANK, "blink_pre");
        rst = 1'b0;
        cyc(5, 5, BLANK, BLANK, "blink_rst");
        rst = 1'b1; en = 1'b1; x_pos = 10'd265; y_pos = 10'd277;
        vis = 7'b0110011;
        for (int f = 0; f < 7; f++) begin
            cyc(0, 0, bg(12'h00F), bg(12'h00F), "blink_fs");
            cyc(265, 277, vis[f] ? sp(12'hF00) : bg(12'h00F),
                vis[f] ? sp(12'hF00) : bg(12'h00F), $sformatf("blink_f%0d", f));
        end
        cyc(5, 5, BLANK, BLANK, "blink_rst_mid");
        rst = 1'b0;
        cyc(5, 5, BLANK, BLANK, "blink_rst_mid2");
        rst = 1'b1;
        cyc(0, 0, bg(12'h00F), bg(12'h00F), "blink_fs_again");
        cyc(265, 277, sp(12'hF00), sp(12'hF00), "blink_after_rst");
`else
        vis = 7'b0;
`endif

        // drain
        en = 1'b0;
        cyc(5, 5, DC, DC, "drain");
        cyc(5, 5, DC, DC, "drain");
        cyc(5, 5, DC, DC, "drain");
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
